fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined femtoRV32 core. Holds the program counter and forms next-PC as PC+4 or the EX-stage branch/jump target. Drives a req/ack instruction-memory handshake and loads the IF/ID pipeline register consumed by decode. Handles hazard-unit stalls and branch flushes, including redirects that arrive while a memory request is outstanding.

## Interface
- N, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  EX: taken branch/jump, flush IF/ID
- redirect_pc  in  N  EX: target address
- imem_req  out  1  instruction request
- imem_addr  out  N  request address
- imem_ack  in  1  response valid (same cycle as req allowed)
- imem_rdata  in  32  instruction word, valid with ack
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  N  PC of ifid_inst
- ifid_pc4  out  N  ifid_pc+4
- ifid_inst  out  32  instruction

## Operation
- FSM states: IDLE, REQ, HOLD, DROP.
- IDLE: reset state; imem_req=0; unconditionally → REQ.
- REQ: imem_req=1, imem_addr=pc.
  - ack & !stall & !redirect: load IF/ID (valid=1, pc, pc+4, rdata); pc<=pc+4; stay REQ.
  - ack & stall & !redirect: buffer rdata; → HOLD.
  - !ack & redirect: pc<=redirect_pc; → DROP.
  - ack & redirect: discard rdata; pc<=redirect_pc; stay REQ.
- HOLD: imem_req=0. On !stall: load IF/ID from buffer; pc<=pc+4; → REQ.
- DROP: imem_req=1, imem_addr = old address, latched on entry. On ack: discard data → REQ. A further redirect updates pc only.
- Redirect in any state clears ifid_valid at the next edge. Redirect beats stall. Redirect in HOLD discards the buffer; pc<=redirect_pc; → REQ.
- Stall without redirect holds all IF/ID fields.
- Handshake rule: while imem_req=1 and no ack, imem_addr is stable.
- Next-PC arithmetic: N-bit, wraps at 2^N silently. redirect_pc is used unmodified.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_inst=32'h0000_0013 (NOP).
- First imem_req: first cycle after rst deasserts, at RESET_PC.
- Latency: ack in cycle t → ifid_valid/ifid_inst visible after edge t+1.
- Throughput: 1 instr/cycle with zero-wait memory.
- Redirect in cycle t: ifid_valid=0 after edge t+1. With zero-wait memory, the target instruction is valid after edge t+2.
- rst mid-request: outstanding request abandoned; memory must tolerate req dropping without ack.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output ports perf_fetched (32) and perf_wait (32).
  - perf_fetched: +1 per IF/ID load with valid=1.
  - perf_wait: +1 per cycle in REQ/DROP without ack.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package fetch_pkg:
  - state encoding localparams IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DROP=2'd3
  - NOP_INST=32'h0000_0013
- Sub-module: one instance of the existing 2:1 mux (N-bit) selects between pc+4 and redirect_pc, with sel=redirect.

## Test plan
- Reset then zero-wait ack every cycle, rdata = addr-derived: ifid_pc runs 0,4,8,12; ifid_pc4 = ifid_pc+4; ifid_valid=1 from the second post-reset edge.
- stall=1 for 3 cycles with an ack in the first: state HOLD, IF/ID unchanged, imem_req=0. On release, the buffered instruction loads and the next request is at pc+4.
- Ack delayed 4 cycles (ack=0 at addr 0x10): imem_addr stays 0x10 throughout, ifid_valid unchanged.
- redirect to 0x100 while req at 0x20 is unacked: DROP keeps addr 0x20 until ack, data discarded, next req at 0x100, ifid_valid=0.
- redirect to 0x200 coincident with ack and stall: IF/ID flushed (valid=0), ack data discarded, next req at 0x200.
- rst asserted mid-HOLD: all outputs return to reset values immediately. With FETCH_PERF_CNT_EN, perf counters are 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the femtoRV32 instruction-fetch stage:
// FSM state encoding and the NOP used to seed the IF/ID register.
package fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        HOLD = ST_HOLD,
        DROP = ST_DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_mux.sv
// Generic N-bit 2:1 multiplexer: y = sel ? b : a.
module fetch_unit_mux #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/fetch_unit.sv
// femtoRV32 instruction fetch: PC, req/ack imem handshake, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_wait counters.
//
// state | meaning
// IDLE  | post-reset, no request yet
// REQ   | requesting instruction at pc
// HOLD  | ack arrived under stall, instruction parked in buffer
// DROP  | redirect overtook an unacked request; finishing it, data discarded
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         ifid_valid,
    output logic [N-1:0] ifid_pc,
    output logic [N-1:0] ifid_pc4,
    output logic [31:0]  ifid_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_wait
`endif
);

    fetch_state_t state_q, state_d;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_next;
    logic [N-1:0] drop_addr_q;
    logic [31:0]  buf_q;

    logic         pc_en;
    logic         ifid_load;
    logic         buf_en;
    logic         drop_latch;
    logic [31:0]  load_inst;

    assign pc_plus4 = pc_q + N'(4);

    fetch_unit_mux #(.N(N)) u_pc_mux (
        .a   (pc_plus4),
        .b   (redirect_pc),
        .sel (redirect),
        .y   (pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_load  = 1'b0;
        buf_en     = 1'b0;
        drop_latch = 1'b0;
        load_inst  = imem_rdata;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_en   = redirect;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_en = 1'b1;
                    if (!imem_ack) begin
                        state_d    = DROP;
                        drop_latch = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        buf_en  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_en     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_en   = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    load_inst = buf_q;
                    pc_en     = 1'b1;
                    state_d   = REQ;
                end
            end
            DROP: begin
                // keep presenting the abandoned address until memory answers
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                pc_en     = redirect;
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_q       <= NOP_INST;
        end else begin
            if (pc_en) begin
                pc_q <= pc_next;
            end
            if (drop_latch) begin
                drop_addr_q <= pc_q;
            end
            if (buf_en) begin
                buf_q <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
        end else if (ifid_load) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc_q;
            ifid_pc4   <= pc_plus4;
            ifid_inst  <= load_inst;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
        end else begin
            if (ifid_load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem_req && !imem_ack) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/ack traffic, compared against a behavioural fetch model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_inst   (ifid_inst)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_wait    (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: what the fetch stage owes the pipeline, in terms of
    // "is anything started", "is a word parked", "is a stale fetch in flight".
    bit          m_started;
    bit          m_parked;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_parked_word;
    logic [31:0] m_pc;
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_inst;
    logic [31:0] m_fetched;
    logic [31:0] m_wait;

    function automatic bit exp_req();
        return m_started && !m_parked;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    function automatic logic [31:0] idata(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic model_reset();
        m_started = 0; m_parked = 0; m_stale = 0;
        m_stale_addr = 0; m_parked_word = 0; m_pc = 0;
        m_v = 0; m_ipc = 0; m_ipc4 = 0; m_inst = 32'h0000_0013;
        m_fetched = 0; m_wait = 0;
    endtask

    task automatic deliver(input logic [31:0] a, input logic [31:0] w);
        m_v = 1; m_ipc = a; m_ipc4 = a + 32'd4; m_inst = w;
        m_fetched = m_fetched + 32'd1;
        m_pc = a + 32'd4;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit ak, input logic [31:0] rdt);
        bit req;
        bit got;
        req = exp_req();
        got = ak && req;
        if (req && !got) m_wait = m_wait + 32'd1;
        if (rd) m_v = 0;
        if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = rpc;
        end else if (m_parked) begin
            if (rd) begin
                m_parked = 0;
                m_pc = rpc;
            end else if (!st) begin
                m_parked = 0;
                deliver(m_pc, m_parked_word);
            end
        end else if (m_stale) begin
            if (got) m_stale = 0;
            if (rd) m_pc = rpc;
        end else if (rd) begin
            if (!got) begin
                m_stale = 1;
                m_stale_addr = m_pc;
            end
            m_pc = rpc;
        end else if (got) begin
            if (st) begin
                m_parked = 1;
                m_parked_word = rdt;
            end else begin
                deliver(m_pc, rdt);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req",   32'(imem_req),   32'(exp_req()));
        chk("imem_addr",  imem_addr,       exp_addr());
        chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
        chk("ifid_pc",    ifid_pc,         m_ipc);
        chk("ifid_pc4",   ifid_pc4,        m_ipc4);
        chk("ifid_inst",  ifid_inst,       m_inst);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_wait",    perf_wait,    m_wait);
`endif
    endtask

    // Called at a falling edge: check, drive, advance model, move to next falling edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                        input bit ak, input logic [31:0] rdt);
        check_all();
        stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak; imem_rdata = rdt;
        model_step(st, rd, rpc, ak, rdt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_req"},   32'(imem_req),   32'h0);
        chk({pfx, "_addr"},  imem_addr,       32'h0);
        chk({pfx, "_valid"}, 32'(ifid_valid), 32'h0);
        chk({pfx, "_pc"},    ifid_pc,         32'h0);
        chk({pfx, "_pc4"},   ifid_pc4,        32'h0);
        chk({pfx, "_inst"},  ifid_inst,       32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
        chk({pfx, "_perf_fetched"}, perf_fetched, 32'h0);
        chk({pfx, "_perf_wait"},    perf_wait,    32'h0);
`endif
    endtask

    initial begin
        bit          st, rd, ak;
        logic [31:0] rpc;

        rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // IDLE cycle, then zero-wait fetch of 0,4,8,12
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, idata(exp_addr()));
        chk("seq_pc",    ifid_pc,         32'h0000_000C);
        chk("seq_pc4",   ifid_pc4,        32'h0000_0010);
        chk("seq_valid", 32'(ifid_valid), 32'h1);
        chk("seq_inst",  ifid_inst,       idata(32'h0000_000C));

        // delayed ack at 0x10
        for (int i = 0; i < 4; i++) begin
            chk("wait_addr", imem_addr, 32'h0000_0010);
            step(0, 0, 0, 0, $urandom);
        end
        chk("wait_addr", imem_addr, 32'h0000_0010);
        chk("wait_pc",   ifid_pc,   32'h0000_000C);
        step(0, 0, 0, 1, idata(32'h10));
        chk("wait_done_pc", ifid_pc, 32'h0000_0010);

        // stall for 3 cycles, ack in the first (at 0x14)
        step(1, 0, 0, 1, idata(32'h14));
        for (int i = 0; i < 2; i++) begin
            chk("hold_req", 32'(imem_req), 32'h0);
            chk("hold_pc",  ifid_pc,       32'h0000_0010);
            step(1, 0, 0, 0, 0);
        end
        chk("hold_req", 32'(imem_req), 32'h0);
        step(0, 0, 0, 0, 0);
        chk("release_pc",   ifid_pc,   32'h0000_0014);
        chk("release_inst", ifid_inst, idata(32'h14));
        chk("release_addr", imem_addr, 32'h0000_0018);

        step(0, 0, 0, 1, idata(32'h18));
        step(0, 0, 0, 1, idata(32'h1C));

        // redirect to 0x100 with request at 0x20 unacked
        chk("pre_redirect_addr", imem_addr, 32'h0000_0020);
        step(0, 1, 32'h100, 0, 0);
        chk("drop_addr",  imem_addr,       32'h0000_0020);
        chk("drop_valid", 32'(ifid_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        chk("drop_addr_hold", imem_addr, 32'h0000_0020);
        step(0, 0, 0, 1, $urandom);
        chk("post_drop_addr",  imem_addr,       32'h0000_0100);
        chk("post_drop_valid", 32'(ifid_valid), 32'h0);
        step(0, 0, 0, 1, idata(32'h100));
        chk("target_pc",    ifid_pc,         32'h0000_0100);
        chk("target_valid", 32'(ifid_valid), 32'h1);

        // redirect to 0x200 coincident with ack and stall
        step(1, 1, 32'h200, 1, $urandom);
        chk("flush_valid", 32'(ifid_valid), 32'h0);
        chk("flush_addr",  imem_addr,       32'h0000_0200);
        chk("flush_req",   32'(imem_req),   32'h1);
        step(0, 0, 0, 1, idata(32'h200));
        step(1, 0, 0, 1, idata(32'h204));
        step(1, 0, 0, 0, 0);

        // asynchronous reset while parked in HOLD
        check_all();
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_hold");
        model_reset();
        stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0;
        @(negedge clk);
        rst = 1'b0;

        // PC wrap at 2^32
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 1, $urandom);
        step(0, 0, 0, 1, idata(32'hFFFF_FFFC));
        chk("wrap_pc",   ifid_pc,   32'hFFFF_FFFC);
        chk("wrap_pc4",  ifid_pc4,  32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + {28'h0, 2'b00, 2'(i)} * 32'd4)
                                              : $urandom;
            ak  = exp_req() && ($urandom_range(0, 2) != 0);
            step(st, rd, rpc, ak, $urandom);
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
